shift_register: RTL and testbench

SHIFT_REGISTER -- requirements
Module: shift_register

---
 rtl/shift_register.sv | 61 ++++++
 tb/tb_shift_register.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/shift_register.sv
// Serial-in, parallel-out shift register with a level-sensitive dump into a
// held output word, a saturating fill counter and a one-cycle dump strobe.
module shift_register #(
  parameter int               WIDTH       = 12,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int              CW          = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_in,
  input  logic             ShiftDump,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] data_out,
  output logic             dump_valid,
  output logic [CW-1:0]    bit_count,
  output logic             full
);

  localparam logic [CW-1:0] COUNT_MAX = CW'(WIDTH);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             dump_valid_q, dump_valid_d;
  logic [CW-1:0]    bit_count_q, bit_count_d;

  always_comb begin
    q_d          = {q_q[WIDTH-2:0], data_in};
    data_out_d   = data_out_q;
    dump_valid_d = ShiftDump;
    bit_count_d  = bit_count_q;
    if (ShiftDump) begin
      // Dump captures the pre-edge contents; the bit entering on this same
      // edge starts the new count.
      data_out_d  = q_q;
      bit_count_d = CW'(1);
    end else if (bit_count_q != COUNT_MAX) begin
      bit_count_d = bit_count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q          <= RESET_VALUE;
      data_out_q   <= RESET_VALUE;
      dump_valid_q <= 1'b0;
      bit_count_q  <= '0;
    end else begin
      q_q          <= q_d;
      data_out_q   <= data_out_d;
      dump_valid_q <= dump_valid_d;
      bit_count_q  <= bit_count_d;
    end
  end

  assign q          = q_q;
  assign data_out   = data_out_q;
  assign dump_valid = dump_valid_q;
  assign bit_count  = bit_count_q;
  assign full       = (bit_count_q == COUNT_MAX);

endmodule

// File: tb/tb_shift_register.sv
// Directed bench for shift_register: arithmetic reference model checked every
// cycle, plus hand-computed literal checks on the key scenarios.
module tb_shift_register;
  localparam int W  = 12;
  localparam int CW = $clog2(W + 1);
  localparam int MASK = (1 << W) - 1;

  logic          clk;
  logic          reset;
  logic          data_in;
  logic          ShiftDump;
  logic [W-1:0]  q;
  logic [W-1:0]  data_out;
  logic          dump_valid;
  logic [CW-1:0] bit_count;
  logic          full;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model state (plain integers)
  int m_q, m_dout, m_bc;
  bit m_dv;

  shift_register #(.WIDTH(W), .RESET_VALUE('0)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .ShiftDump(ShiftDump),
    .q(q), .data_out(data_out), .dump_valid(dump_valid),
    .bit_count(bit_count), .full(full)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout exp=finish");
    n_miss++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: act=0x%0h exp=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: shift = multiply by two plus new bit, truncated to W bits.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q = 0; m_dout = 0; m_bc = 0; m_dv = 1'b0;
    end else begin
      if (ShiftDump) begin
        m_dout = m_q;
        m_bc   = 1;
      end else begin
        m_bc = (m_bc + 1 > W) ? W : m_bc + 1;
      end
      m_dv = ShiftDump;
      m_q  = ((m_q * 2) + int'(data_in)) & MASK;
    end
  end

  // Compare process: every cycle, 1 time unit after the active edge.
  always @(posedge clk) begin
    #1;
    check("cyc_q",          int'(q),          m_q);
    check("cyc_data_out",   int'(data_out),   m_dout);
    check("cyc_dump_valid", int'(dump_valid), int'(m_dv));
    check("cyc_bit_count",  int'(bit_count),  m_bc);
    check("cyc_full",       int'(full),       int'(m_bc == W));
  end

  // driver: inputs change 2 units after the edge, away from sampling.
  task automatic drive(input bit din, input bit dump);
    data_in   = din;
    ShiftDump = dump;
    @(posedge clk);
    #2;
  endtask

  task automatic check_all(input string tag, input int eq, input int edo,
                           input int edv, input int ebc, input int efull);
    check({tag, "_q"},          int'(q),          eq);
    check({tag, "_data_out"},   int'(data_out),   edo);
    check({tag, "_dump_valid"}, int'(dump_valid), edv);
    check({tag, "_bit_count"},  int'(bit_count),  ebc);
    check({tag, "_full"},       int'(full),       efull);
  endtask

  // Asynchronous reset pulse starting between edges; checks before any edge.
  task automatic async_reset(input string tag);
    #1 reset = 1'b0;
    #1 check_all(tag, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #2;
  endtask

  initial begin
    int pat;
    reset = 1'b1; data_in = 1'b0; ShiftDump = 1'b0;
    #1 reset = 1'b0;
    #1 check_all("rst_async", 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #2 check_all("rst_held", 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;

    // single one then zeros
    drive(1, 0); check_all("walk1", 'h001, 0, 0, 1, 0);
    check("model_pin_q", m_q, 'h001);
    drive(0, 0); check_all("walk2", 'h002, 0, 0, 2, 0);
    drive(0, 0); check_all("walk3", 'h004, 0, 0, 3, 0);
    drive(0, 0); check_all("walk4", 'h008, 0, 0, 4, 0);

    // first dump
    drive(0, 1); check_all("dump1", 'h010, 'h008, 1, 1, 0);
    check("model_pin_dout", m_dout, 'h008);
    drive(0, 0); check_all("post1", 'h020, 'h008, 0, 2, 0);
    drive(0, 0); check_all("post2", 'h040, 'h008, 0, 3, 0);
    drive(0, 0); check_all("post3", 'h080, 'h008, 0, 4, 0);
    drive(0, 1); check_all("dump2", 'h100, 'h080, 1, 1, 0);

    // mid-cycle reset discards contents and a pending dump strobe
    async_reset("rst_mid");

    // 101100111010 MSB first
    pat = 'hB3A;
    for (int i = W - 1; i >= 0; i--) drive(pat[i], 0);
    check_all("pat_full", 'hB3A, 0, 0, 12, 1);
    check("model_pin_bc", m_bc, 12);
    drive(1, 0); check_all("sat1", 'h675, 0, 0, 12, 1);
    drive(0, 0); check_all("sat2", 'hCEA, 0, 0, 12, 1);
    drive(1, 0); check_all("sat3", 'h9D5, 0, 0, 12, 1);

    // dump held for three edges
    drive(0, 1); check_all("hold1", 'h3AA, 'h9D5, 1, 1, 0);
    drive(1, 1); check_all("hold2", 'h755, 'h3AA, 1, 1, 0);
    drive(1, 1); check_all("hold3", 'hEAB, 'h755, 1, 1, 0);
    // reset mid-hold, ShiftDump still high, edges occur while in reset
    #1 reset = 1'b0;
    #1 check_all("hold_rst", 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #2 check_all("hold_rst_edge", 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    data_in = 1'b1;
    @(posedge clk);
    #2 check_all("first_after_rst", 'h001, 0, 1, 1, 0);

    // mixed traffic, covered by the per-cycle model compare
    for (int i = 0; i < 60; i++)
      drive(1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0));
    drive(0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
